// File: rtl/fcs_pkg.sv
// Shared CRC-32 definitions for the FCS checker.
// - CRC32_POLY / CRC32_INIT: non-reflected Ethernet CRC-32, MSB-first per byte.
// - CRC32_PASS: all-ones pattern that the transmitter XORs onto the FCS.
// - CRC32_RESIDUE: register value after a frame whose trailing FCS is the
//   complemented CRC, i.e. CRC32_PASS carried through 32 more shifts.
// - crc32_byte(): one-byte CRC update, bit 7 enters first.
// - fcs_state_t: checker FSM states.
package fcs_pkg;

    localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_PASS = 32'hFFFFFFFF;

    typedef enum logic {
        IDLE     = 1'b0,
        IN_FRAME = 1'b1
    } fcs_state_t;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc;
        for (int i = 7; i >= 0; i--) begin
            if (c[31] ^ data[i]) c = {c[30:0], 1'b0} ^ CRC32_POLY;
            else                 c = {c[30:0], 1'b0};
        end
        return c;
    endfunction

    // Appending the complemented CRC leaves (all-ones * x^32) mod POLY in the
    // register; four zero bytes fed through the update compute exactly that.
    localparam logic [31:0] CRC32_RESIDUE =
        crc32_byte(crc32_byte(crc32_byte(crc32_byte(CRC32_PASS, 8'h00), 8'h00), 8'h00), 8'h00);

endpackage

// File: rtl/crc32_lanes.sv
// Combinational multi-lane CRC-32 update.
// Ports:
//   crc_in  - register value before this beat
//   data    - lane k = data[8k+7:8k], lane 0 first in stream order
//   nbytes  - number of valid lanes (0..DATA_BYTES), lanes 0..nbytes-1 used
//   crc_out - register value after chaining crc32_byte over the valid lanes
module crc32_lanes
    import fcs_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int NB_W       = $clog2(DATA_BYTES + 1)
) (
    input  logic [31:0]             crc_in,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic [NB_W-1:0]         nbytes,
    output logic [31:0]             crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in;
        for (int k = 0; k < DATA_BYTES; k++) begin
            if (k < int'(nbytes)) c = crc32_byte(c, data[8*k +: 8]);
        end
        crc_out = c;
    end

endmodule

// File: rtl/fcs_check_multilane.sv
// Ethernet FCS checker for frames delivered DATA_BYTES bytes per beat.
// Ports:
//   clk, reset        - clock, synchronous active-high reset
//   in_valid          - beat qualifier; gaps allowed, no backpressure
//   in_sof / in_eof   - first / last beat of a frame (qualified by in_valid)
//   in_nbytes         - valid lanes on the eof beat (0 means all lanes)
//   data_in           - beat data, lane 0 first
//   in_abort          - drop the open frame (does not need in_valid)
//   result_valid      - one-cycle pulse, one cycle after each completed eof
//   fcs_error, runt_error, frame_len - frame verdict, valid with result_valid
//   good_cnt, bad_cnt - saturating frame statistics
// Handshake: the source presents a beat whenever in_valid is high and it is
// always consumed on that clock edge; result_valid is a single-cycle pulse
// with no acknowledge, so the consumer must capture the verdict that cycle.
module fcs_check_multilane
    import fcs_pkg::*;
#(
    parameter int DATA_BYTES = 4,
    parameter int MIN_BYTES  = 64,
    parameter int LEN_W      = 16,
    parameter int CNT_W      = 32
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    input  logic                             in_sof,
    input  logic                             in_eof,
    input  logic [$clog2(DATA_BYTES+1)-1:0]  in_nbytes,
    input  logic [8*DATA_BYTES-1:0]          data_in,
    input  logic                             in_abort,
    output logic                             result_valid,
    output logic                             fcs_error,
    output logic                             runt_error,
    output logic [LEN_W-1:0]                 frame_len,
    output logic [CNT_W-1:0]                 good_cnt,
    output logic [CNT_W-1:0]                 bad_cnt
);

    localparam int              NB_W    = $clog2(DATA_BYTES + 1);
    localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(MIN_BYTES);

    fcs_state_t       state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic             frame_done;

    logic             start;
    logic [NB_W-1:0]  lanes;
    logic [31:0]      crc_lane_in, crc_lane_out;
    logic [LEN_W-1:0] len_base, len_adv;
    logic [LEN_W:0]   len_sum;
    logic             fcs_bad, runt;

    // A new frame starts from init whether the block is idle or a frame is
    // open (the open one is dropped); abort on the same beat wins.
    always_comb begin
        start = in_valid && in_sof && !in_abort;
        lanes = NB_W'(DATA_BYTES);
        if (in_eof && (in_nbytes != '0) && (in_nbytes < NB_W'(DATA_BYTES)))
            lanes = in_nbytes;
        crc_lane_in = start ? CRC32_INIT : crc_q;
        len_base    = start ? '0 : len_q;
        len_sum     = {1'b0, len_base} + (LEN_W+1)'(lanes);
        len_adv     = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
    end

    crc32_lanes #(
        .DATA_BYTES (DATA_BYTES),
        .NB_W       (NB_W)
    ) u_crc (
        .crc_in  (crc_lane_in),
        .data    (data_in),
        .nbytes  (lanes),
        .crc_out (crc_lane_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            crc_q   <= CRC32_INIT;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            len_q   <= len_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        crc_d      = crc_q;
        len_d      = len_q;
        frame_done = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    crc_d = crc_lane_out;
                    len_d = len_adv;
                    if (in_eof) frame_done = 1'b1;
                    else        state_d    = IN_FRAME;
                end
            end
            IN_FRAME: begin
                if (in_abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    crc_d = crc_lane_out;
                    len_d = len_adv;
                    if (in_eof) begin
                        frame_done = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign fcs_bad = (crc_d != CRC32_RESIDUE);
    assign runt    = (len_d < MIN_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            result_valid <= 1'b0;
            fcs_error    <= 1'b0;
            runt_error   <= 1'b0;
            frame_len    <= '0;
            good_cnt     <= '0;
            bad_cnt      <= '0;
        end else begin
            result_valid <= frame_done;
            if (frame_done) begin
                fcs_error  <= fcs_bad;
                runt_error <= runt;
                frame_len  <= len_d;
                if (fcs_bad || runt) begin
                    if (bad_cnt != '1) bad_cnt <= bad_cnt + CNT_W'(1);
                end else begin
                    if (good_cnt != '1) good_cnt <= good_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fcs_check_multilane.sv
// Self-checking bench for fcs_check_multilane. Five instances cover lane
// widths 1/2/4/8, both runt thresholds and a 2-bit saturating counter.
module tb_fcs_check_multilane;
    import fcs_pkg::*;

    localparam int NI = 5;
    localparam int RW = 114;   // {due[31:0], fe, re, len[15:0], good[31:0], bad[31:0]}

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        v[NI], s[NI], e[NI], ab[NI];
    logic [63:0] d[NI];
    logic [3:0]  nb[NI];
    logic        rv[NI], fe[NI], re[NI];
    logic [15:0] fl[NI];
    logic [31:0] gc[NI], bc[NI];
    logic [1:0]  gc3, bc3;
    assign gc[3] = {30'd0, gc3};
    assign bc[3] = {30'd0, bc3};

    fcs_check_multilane #(.DATA_BYTES(4), .MIN_BYTES(8)) u0 (
        .clk(clk), .reset(reset), .in_valid(v[0]), .in_sof(s[0]), .in_eof(e[0]),
        .in_nbytes(nb[0][2:0]), .data_in(d[0][31:0]), .in_abort(ab[0]),
        .result_valid(rv[0]), .fcs_error(fe[0]), .runt_error(re[0]),
        .frame_len(fl[0]), .good_cnt(gc[0]), .bad_cnt(bc[0]));
    fcs_check_multilane #(.DATA_BYTES(1), .MIN_BYTES(8)) u1 (
        .clk(clk), .reset(reset), .in_valid(v[1]), .in_sof(s[1]), .in_eof(e[1]),
        .in_nbytes(nb[1][0:0]), .data_in(d[1][7:0]), .in_abort(ab[1]),
        .result_valid(rv[1]), .fcs_error(fe[1]), .runt_error(re[1]),
        .frame_len(fl[1]), .good_cnt(gc[1]), .bad_cnt(bc[1]));
    fcs_check_multilane #(.DATA_BYTES(2), .MIN_BYTES(8)) u2 (
        .clk(clk), .reset(reset), .in_valid(v[2]), .in_sof(s[2]), .in_eof(e[2]),
        .in_nbytes(nb[2][1:0]), .data_in(d[2][15:0]), .in_abort(ab[2]),
        .result_valid(rv[2]), .fcs_error(fe[2]), .runt_error(re[2]),
        .frame_len(fl[2]), .good_cnt(gc[2]), .bad_cnt(bc[2]));
    fcs_check_multilane #(.DATA_BYTES(8), .MIN_BYTES(8), .CNT_W(2)) u3 (
        .clk(clk), .reset(reset), .in_valid(v[3]), .in_sof(s[3]), .in_eof(e[3]),
        .in_nbytes(nb[3][3:0]), .data_in(d[3][63:0]), .in_abort(ab[3]),
        .result_valid(rv[3]), .fcs_error(fe[3]), .runt_error(re[3]),
        .frame_len(fl[3]), .good_cnt(gc3), .bad_cnt(bc3));
    fcs_check_multilane #(.DATA_BYTES(4)) u4 (
        .clk(clk), .reset(reset), .in_valid(v[4]), .in_sof(s[4]), .in_eof(e[4]),
        .in_nbytes(nb[4][2:0]), .data_in(d[4][31:0]), .in_abort(ab[4]),
        .result_valid(rv[4]), .fcs_error(fe[4]), .runt_error(re[4]),
        .frame_len(fl[4]), .good_cnt(gc[4]), .bad_cnt(bc[4]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int             total = 0;
    int             bad = 0;
    int             mgood[NI], mbad[NI];
    logic [RW-1:0]  exp_q[NI][$];
    logic [7:0]     frm[$];
    logic [RW-1:0]  mon_r;

    logic [7:0] base[13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37,
                             8'h38, 8'h39, 8'hFC, 8'h89, 8'h19, 8'h18};

    typedef struct {
        int          inst;
        int          gap;
        bit          corrupt;
        logic        fe;
        logic        re;
        logic [15:0] len;
    } vec_t;
    vec_t tbl[9];

    function automatic int db_of(input int i);
        case (i)
            1: return 1;
            2: return 2;
            3: return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int min_of(input int i);
        return (i == 4) ? 64 : 8;
    endfunction

    function automatic int cap_of(input int i);
        return (i == 3) ? 3 : 32'hFFFFFFFF;
    endfunction

    task automatic chk(input string name, input int inst, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%0h want=%0h", name, inst, act, exp);
        end
    endtask

    // Reference check: complement the first and last four bytes (overlaps
    // cancel) and require a zero remainder from a zero register. Frames under
    // four bytes use the raw register against the all-ones*x^32 residue.
    function automatic logic model_fcs_err();
        int          n;
        logic [31:0] c, resid;
        logic [7:0]  b;
        n = frm.size();
        if (n < 4) begin
            resid = 32'hFFFFFFFF;
            for (int j = 0; j < 4; j++) resid = crc32_byte(resid, 8'h00);
            c = 32'hFFFFFFFF;
            for (int j = 0; j < n; j++) c = crc32_byte(c, frm[j]);
            return c != resid;
        end
        c = 32'h0;
        for (int j = 0; j < n; j++) begin
            b = frm[j];
            if (j < 4)     b = ~b;
            if (j >= n - 4) b = ~b;
            c = crc32_byte(c, b);
        end
        return c != 32'h0;
    endfunction

    task automatic make_good(input int n);
        logic [31:0] c;
        frm.delete();
        if (n < 4) begin
            for (int j = 0; j < n; j++) frm.push_back(8'($urandom));
            return;
        end
        c = 32'hFFFFFFFF;
        for (int j = 0; j < n - 4; j++) begin
            frm.push_back(8'($urandom));
            c = crc32_byte(c, frm[j]);
        end
        c = ~c;
        frm.push_back(c[31:24]);
        frm.push_back(c[23:16]);
        frm.push_back(c[15:8]);
        frm.push_back(c[7:0]);
    endtask

    task automatic push_exp(input int inst, input logic xfe, input logic xre,
                            input logic [15:0] xlen);
        if (xfe || xre) begin
            if (mbad[inst] != cap_of(inst)) mbad[inst]++;
        end else begin
            if (mgood[inst] != cap_of(inst)) mgood[inst]++;
        end
        exp_q[inst].push_back({32'(cyc + 1), xfe, xre, xlen, 32'(mgood[inst]), 32'(mbad[inst])});
    endtask

    task automatic tick(input int inst);
        @(posedge clk);
        #1;
        v[inst]  = 1'b0;
        s[inst]  = 1'b0;
        e[inst]  = 1'b0;
        ab[inst] = 1'b0;
        nb[inst] = 4'($urandom);
        d[inst]  = {$urandom, $urandom};
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int inst, input int gap, input int abort_beat,
                              input bit keep_open, input bit use_tbl, input logic tfe,
                              input logic tre, input logic [15:0] tlen);
        int          db, n, nbeats, rem;
        logic [63:0] w;
        db = db_of(inst);
        n = frm.size();
        nbeats = (n + db - 1) / db;
        for (int b = 0; b < nbeats; b++) begin
            if (b > 0 && gap > 0) idle($urandom_range(1, gap));
            if (b == abort_beat) begin
                ab[inst] = 1'b1;
                tick(inst);
                return;
            end
            if (keep_open && b == nbeats - 1) return;
            w = {$urandom, $urandom};
            for (int k = 0; k < db; k++)
                if (b * db + k < n) w[8*k +: 8] = frm[b * db + k];
            rem = n - b * db;
            v[inst] = 1'b1;
            s[inst] = (b == 0);
            e[inst] = (b == nbeats - 1);
            d[inst] = w;
            if (b == nbeats - 1) begin
                nb[inst] = (rem == db && $urandom_range(0, 1) == 1) ? 4'd0 : 4'(rem);
                if (use_tbl) push_exp(inst, tfe, tre, tlen);
                else push_exp(inst, model_fcs_err(), n < min_of(inst), 16'(n));
            end else begin
                nb[inst] = 4'($urandom_range(0, 15));
            end
            tick(inst);
        end
    endtask

    task automatic drain();
        int pend;
        pend = 0;
        for (int t = 0; t < 50; t++) begin
            pend = 0;
            for (int i = 0; i < NI; i++) pend += exp_q[i].size();
            if (pend == 0) break;
            idle(1);
        end
        chk("drain_empty", -1, pend, 0);
        idle(2);
    endtask

    task automatic chk_zero(input string tag, input int i);
        chk({tag, "_result_valid"}, i, rv[i], 0);
        chk({tag, "_fcs_error"},    i, fe[i], 0);
        chk({tag, "_runt_error"},   i, re[i], 0);
        chk({tag, "_frame_len"},    i, fl[i], 0);
        chk({tag, "_good_cnt"},     i, gc[i], 0);
        chk({tag, "_bad_cnt"},      i, bc[i], 0);
    endtask

    // Scoreboard: every result must match the head of its instance's queue,
    // arrive exactly at the recorded cycle, and never appear unannounced.
    always @(negedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NI; i++) begin
                if (rv[i]) begin
                    if (exp_q[i].size() == 0) begin
                        chk("spurious_result", i, rv[i], 0);
                    end else begin
                        mon_r = exp_q[i].pop_front();
                        chk("latency",    i, cyc,   mon_r[113:82]);
                        chk("fcs_error",  i, fe[i], mon_r[81]);
                        chk("runt_error", i, re[i], mon_r[80]);
                        chk("frame_len",  i, fl[i], mon_r[79:64]);
                        chk("good_cnt",   i, gc[i], mon_r[63:32]);
                        chk("bad_cnt",    i, bc[i], mon_r[31:0]);
                    end
                end else if (exp_q[i].size() > 0) begin
                    mon_r = exp_q[i][0];
                    if (int'(mon_r[113:82]) < cyc) begin
                        chk("missing_result", i, rv[i], 1);
                        void'(exp_q[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        int inst, n, ab_at;
        for (int i = 0; i < NI; i++) begin
            v[i] = 1'b0; s[i] = 1'b0; e[i] = 1'b0; ab[i] = 1'b0;
            nb[i] = 4'd0; d[i] = 64'd0;
            mgood[i] = 0; mbad[i] = 0;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < NI; i++) chk_zero("rst", i);

        // Known-answer frame across lane widths, gaps, corruption and runt threshold
        tbl[0] = '{0, 0, 1'b0, 1'b0, 1'b0, 16'd13};
        tbl[1] = '{0, 0, 1'b1, 1'b1, 1'b0, 16'd13};
        tbl[2] = '{0, 3, 1'b0, 1'b0, 1'b0, 16'd13};
        tbl[3] = '{1, 2, 1'b0, 1'b0, 1'b0, 16'd13};
        tbl[4] = '{2, 3, 1'b0, 1'b0, 1'b0, 16'd13};
        tbl[5] = '{3, 1, 1'b0, 1'b0, 1'b0, 16'd13};
        tbl[6] = '{4, 0, 1'b0, 1'b0, 1'b1, 16'd13};
        tbl[7] = '{1, 1, 1'b1, 1'b1, 1'b0, 16'd13};
        tbl[8] = '{3, 0, 1'b1, 1'b1, 1'b0, 16'd13};
        for (int t = 0; t < 9; t++) begin
            frm.delete();
            for (int j = 0; j < 13; j++) frm.push_back(base[j]);
            if (tbl[t].corrupt) frm[12] = 8'h19;
            send_frame(tbl[t].inst, tbl[t].gap, -1, 1'b0, 1'b1, tbl[t].fe, tbl[t].re, tbl[t].len);
            idle(1);
        end
        drain();
        chk("tbl_good_cnt", 0, gc[0], 2);
        chk("tbl_bad_cnt",  0, bc[0], 1);

        // Abort, restart over an open frame, back-to-back frames
        make_good(20); send_frame(0, 0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        make_good(24); send_frame(0, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        make_good(16); send_frame(0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        make_good(12); send_frame(0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        make_good(9);  frm[3] = frm[3] ^ 8'h40;
        send_frame(0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        // abort on the sof beat: frame never starts
        v[0] = 1'b1; s[0] = 1'b1; e[0] = 1'b1; ab[0] = 1'b1; nb[0] = 4'd0;
        tick(0);
        idle(2);
        // three-byte frame
        make_good(3); send_frame(0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        // abort while idle is harmless
        ab[0] = 1'b1; tick(0);
        make_good(8); send_frame(0, 1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drain();

        // Minimum-length frame at the default threshold
        make_good(64); send_frame(4, 1, -1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd64);
        drain();

        // Counter saturation on the 2-bit instance
        repeat (5) begin
            make_good($urandom_range(10, 20));
            send_frame(3, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        end
        drain();
        chk("sat_good_cnt", 3, gc[3], 3);

        // Random frames against the reference model
        repeat (40) begin
            inst = $urandom_range(0, NI - 1);
            n = $urandom_range(1, 80);
            make_good(n);
            if ($urandom_range(0, 3) == 0) begin
                int j;
                j = $urandom_range(0, n - 1);
                frm[j] = frm[j] ^ 8'(1 << $urandom_range(0, 7));
            end
            ab_at = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 10) : -1;
            send_frame(inst, $urandom_range(0, 3), ab_at, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
        end
        drain();

        // Reset with a frame open
        make_good(20); send_frame(0, 0, -1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk_zero("midrst", 0);
        for (int i = 0; i < NI; i++) begin
            mgood[i] = 0;
            mbad[i] = 0;
        end
        idle(3);
        make_good(12); send_frame(0, 0, -1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
